// File: rtl/pc_fetch_stage_if.sv
// Instruction-memory request/response channel and IF/ID slot channel of the fetch stage.
// master = fetch stage side, slave = memory / decode side.
interface pc_fetch_stage_if;
   localparam int unsigned XLEN = 32;

   logic            imem_req_o;
   logic [XLEN-1:0] imem_addr_o;
   logic            imem_gnt_i;
   logic            imem_rvalid_i;
   logic [XLEN-1:0] imem_rdata_i;
   logic            ifid_valid_o;
   logic [XLEN-1:0] ifid_instr_o;
   logic [XLEN-1:0] ifid_pc_o;
   logic            ifid_ready_i;

   modport master (
      output imem_req_o, imem_addr_o, ifid_valid_o, ifid_instr_o, ifid_pc_o,
      input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, ifid_ready_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o, ifid_valid_o, ifid_instr_o, ifid_pc_o,
      output imem_gnt_i, imem_rvalid_i, imem_rdata_i, ifid_ready_i
   );
endinterface

// File: rtl/pc_fetch_stage.sv
// PC register and single-outstanding instruction-fetch sequencer with a one-entry IF/ID slot.
// Optional FETCH_PERF_EN adds saturating stall / squash counters (and the CNT_W parameter).
module pc_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_PERF_EN
   ,
   parameter int unsigned CNT_W    = 16
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       pc_next_in,
   input  logic              redirect_i,
   output logic [31:0]       pc_o,
   output logic [31:0]       pc_plus4_o,
   output logic              misalign_o,
`ifdef FETCH_PERF_EN
   output logic [CNT_W-1:0]  perf_stall_cnt_o,
   output logic [CNT_W-1:0]  perf_squash_cnt_o,
`endif
   pc_fetch_stage_if.master  bus
);
   localparam int unsigned XLEN = 32;

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DROP, S_TRAP} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
   logic            valid_q, valid_d;
   logic            misalign_q, misalign_d;
   logic            slot_free_c, req_c, hs_c;

   // Only request when the response is guaranteed a place in the slot.
   assign slot_free_c = !valid_q || bus.ifid_ready_i;
   assign req_c       = (state_q == S_REQ) && (pc_q[1:0] == 2'b00) && slot_free_c;
   assign hs_c        = req_c && bus.imem_gnt_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         ifid_pc_q  <= '0;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         ifid_pc_q  <= ifid_pc_d;
         valid_q    <= valid_d;
         misalign_q <= misalign_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      ifid_pc_d  = ifid_pc_q;
      valid_d    = valid_q;
      misalign_d = misalign_q;

      if (valid_q && bus.ifid_ready_i) valid_d = 1'b0;

      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (pc_q[1:0] != 2'b00) begin
               state_d    = S_TRAP;
               misalign_d = 1'b1;
            end else if (hs_c) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.imem_rvalid_i) begin
               instr_d   = bus.imem_rdata_i;
               ifid_pc_d = pc_q;
               valid_d   = 1'b1;
               pc_d      = pc_next_in;
               state_d   = S_REQ;
            end
         end
         S_DROP: if (bus.imem_rvalid_i) state_d = S_REQ;
         S_TRAP: state_d = S_TRAP;
         default: state_d = S_IDLE;
      endcase

      // Redirect overrides everything: flush the slot and squash any in-flight response.
      if (redirect_i) begin
         pc_d       = pc_next_in;
         instr_d    = instr_q;
         ifid_pc_d  = ifid_pc_q;
         valid_d    = 1'b0;
         misalign_d = 1'b0;
         case (state_q)
            S_WAIT, S_DROP: state_d = bus.imem_rvalid_i ? S_REQ : S_DROP;
            S_REQ:          state_d = hs_c ? S_DROP : S_REQ;
            default:        state_d = S_REQ;
         endcase
      end
   end

   assign pc_o             = pc_q;
   assign pc_plus4_o       = pc_q + XLEN'(4);
   assign misalign_o       = misalign_q;
   assign bus.imem_req_o   = req_c;
   assign bus.imem_addr_o  = req_c ? pc_q : '0;
   assign bus.ifid_valid_o = valid_q;
   assign bus.ifid_instr_o = instr_q;
   assign bus.ifid_pc_o    = ifid_pc_q;

`ifdef FETCH_PERF_EN
   logic [CNT_W-1:0] stall_q, stall_d, squash_q, squash_d;
   logic             stall_inc_c, squash_inc_c;

   assign stall_inc_c  = (req_c && !bus.imem_gnt_i) || (state_q == S_WAIT) || (state_q == S_DROP);
   assign squash_inc_c = bus.imem_rvalid_i &&
                         ((state_q == S_DROP) || ((state_q == S_WAIT) && redirect_i));

   // Saturating at all-ones.
   always_comb begin
      stall_d  = stall_q;
      squash_d = squash_q;
      if (stall_inc_c && (stall_q != '1))   stall_d  = stall_q + CNT_W'(1);
      if (squash_inc_c && (squash_q != '1)) squash_d = squash_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q  <= '0;
         squash_q <= '0;
      end else begin
         stall_q  <= stall_d;
         squash_q <= squash_d;
      end
   end

   assign perf_stall_cnt_o  = stall_q;
   assign perf_squash_cnt_o = squash_q;
`endif
endmodule

// File: tb/tb_pc_fetch_stage.sv
// Scoreboard bench for pc_fetch_stage: expected fetch addresses and IF/ID entries are queued by
// the stimulus and checked by a monitor; a second instance covers the wrap-around reset PC.
module tb_pc_fetch_stage;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   pc_fetch_stage_if bus ();
   pc_fetch_stage_if bus2 ();

   logic [31:0] pc_o, pc_plus4, pc_next, tgt;
   logic        redirect, misalign;
   logic [31:0] pc2, pc2_plus4;
   logic        misalign2;
`ifdef FETCH_PERF_EN
   logic [15:0] stall_cnt, squash_cnt, stall_cnt2, squash_cnt2;
`endif

   assign pc_next = redirect ? tgt : pc_plus4;

   pc_fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .pc_next_in        (pc_next),
      .redirect_i        (redirect),
      .pc_o              (pc_o),
      .pc_plus4_o        (pc_plus4),
      .misalign_o        (misalign),
`ifdef FETCH_PERF_EN
      .perf_stall_cnt_o  (stall_cnt),
      .perf_squash_cnt_o (squash_cnt),
`endif
      .bus               (bus)
   );

   pc_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
      .clk               (clk),
      .rst_n             (rst_n),
      .pc_next_in        (pc2_plus4),
      .redirect_i        (1'b0),
      .pc_o              (pc2),
      .pc_plus4_o        (pc2_plus4),
      .misalign_o        (misalign2),
`ifdef FETCH_PERF_EN
      .perf_stall_cnt_o  (stall_cnt2),
      .perf_squash_cnt_o (squash_cnt2),
`endif
      .bus               (bus2)
   );

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_ifid_q[$];
   int          lat = 0;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory model for the main instance: rvalid lat+1 cycles after the grant.
   initial begin : mem1
      bit          pend;
      int          cnt;
      logic [31:0] paddr;
      pend = 1'b0; cnt = 0; paddr = '0;
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = '0;
      forever begin
         @(posedge clk); #2;
         bus.imem_rvalid_i = 1'b0;
         if (!rst_n) pend = 1'b0;
         else if (pend) begin
            if (cnt == 0) begin
               bus.imem_rvalid_i = 1'b1;
               bus.imem_rdata_i  = instr_of(paddr);
               pend = 1'b0;
            end else cnt--;
         end
         @(negedge clk);
         if (rst_n && bus.imem_req_o && bus.imem_gnt_i) begin
            pend = 1'b1; cnt = lat; paddr = bus.imem_addr_o;
         end
      end
   end

   // Memory model for the wrap instance: fixed one-cycle response.
   initial begin : mem2
      bit          pend;
      logic [31:0] paddr;
      pend = 1'b0; paddr = '0;
      bus2.imem_rvalid_i = 1'b0;
      bus2.imem_rdata_i  = '0;
      bus2.imem_gnt_i    = 1'b1;
      bus2.ifid_ready_i  = 1'b1;
      forever begin
         @(posedge clk); #2;
         bus2.imem_rvalid_i = 1'b0;
         if (!rst_n) pend = 1'b0;
         else if (pend) begin
            bus2.imem_rvalid_i = 1'b1;
            bus2.imem_rdata_i  = instr_of(paddr);
            pend = 1'b0;
         end
         @(negedge clk);
         if (rst_n && bus2.imem_req_o && bus2.imem_gnt_i) begin
            pend = 1'b1; paddr = bus2.imem_addr_o;
         end
      end
   end

   // Scoreboard monitor: fetch handshakes and IF/ID consumptions.
   initial begin : monitor
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.imem_req_o && bus.imem_gnt_i) begin
               if (exp_addr_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL unexpected_fetch: got addr %h expected no request", bus.imem_addr_o);
               end else begin
                  e = exp_addr_q.pop_front();
                  chk("fetch_addr", bus.imem_addr_o, e);
               end
            end
            if (bus.ifid_valid_o && bus.ifid_ready_i && !redirect) begin
               if (exp_ifid_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL unexpected_ifid: got pc %h expected no entry", bus.ifid_pc_o);
               end else begin
                  e = exp_ifid_q.pop_front();
                  chk("ifid_pc", bus.ifid_pc_o, e);
                  chk("ifid_instr", bus.ifid_instr_o, instr_of(e));
               end
            end
         end
      end
   end

   // Wrap instance: first two fetch addresses after reset.
   initial begin : monitor2
      logic [31:0] exp2 [2];
      int n2;
      exp2[0] = 32'hFFFF_FFFC;
      exp2[1] = 32'h0000_0000;
      n2 = 0;
      forever begin
         @(negedge clk);
         if (rst_n && bus2.imem_req_o && bus2.imem_gnt_i && n2 < 2) begin
            chk("wrap_fetch_addr", bus2.imem_addr_o, exp2[n2]);
            n2++;
         end
      end
   end

   task automatic wait_hs(input logic [31:0] a);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if (bus.imem_req_o && bus.imem_gnt_i && bus.imem_addr_o == a) got = 1'b1;
      end
      if (!got) begin
         tests++; fails++;
         $display("FAIL wait_fetch: got timeout expected fetch of %h", a);
      end
   endtask

   initial begin : stim
      bit got;
      redirect = 1'b0;
      tgt      = '0;
      bus.imem_gnt_i   = 1'b1;
      bus.ifid_ready_i = 1'b1;
      foreach (exp_addr_q[i]) exp_addr_q.delete(i);
      exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h100, 32'h104,
                     32'h180, 32'h184, 32'h200, 32'h204};
      exp_ifid_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h180, 32'h200};

      #12;
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_req", 32'(bus.imem_req_o), 32'h0);
      chk("rst_valid", 32'(bus.ifid_valid_o), 32'h0);
      chk("rst_instr", bus.ifid_instr_o, 32'h0);
      chk("rst_ifid_pc", bus.ifid_pc_o, 32'h0);
      chk("rst_misalign", 32'(misalign), 32'h0);
      chk("wrap_rst_pc", pc2, 32'hFFFF_FFFC);
      chk("wrap_pc_plus4", pc2_plus4, 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Back-pressure: fill the slot with C and hold decode off.
      wait_hs(32'hC);
      @(posedge clk); #1 bus.ifid_ready_i = 1'b0;
      @(posedge clk);
      repeat (5) begin
         @(negedge clk);
         chk("stall_req", 32'(bus.imem_req_o), 32'h0);
         chk("stall_valid", 32'(bus.ifid_valid_o), 32'h1);
         chk("stall_instr", bus.ifid_instr_o, instr_of(32'hC));
      end
      @(posedge clk); #1 bus.ifid_ready_i = 1'b1; lat = 2;

      // Redirect while waiting: response for 0x10 must be dropped.
      wait_hs(32'h10);
      @(posedge clk); #1 redirect = 1'b1; tgt = 32'h100;
      @(posedge clk); #1 redirect = 1'b0; lat = 0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         chk("drop_valid", 32'(bus.ifid_valid_o), 32'h0);
         if (bus.imem_req_o && bus.imem_gnt_i) got = 1'b1;
      end
      chk("redirect_addr", bus.imem_addr_o, 32'h100);

      // Redirect coincident with rvalid.
      wait_hs(32'h104);
      @(posedge clk); #1 redirect = 1'b1; tgt = 32'h180;
      @(posedge clk); #1 redirect = 1'b0;
      @(negedge clk);
      chk("coinc_pc", pc_o, 32'h180);
      chk("coinc_valid", 32'(bus.ifid_valid_o), 32'h0);

      // Misaligned target traps until redirected.
      wait_hs(32'h184);
      @(posedge clk); #1 redirect = 1'b1; tgt = 32'h102;
      @(posedge clk); #1 redirect = 1'b0;
      @(posedge clk);
      repeat (3) begin
         @(negedge clk);
         chk("trap_misalign", 32'(misalign), 32'h1);
         chk("trap_req", 32'(bus.imem_req_o), 32'h0);
         chk("trap_pc", pc_o, 32'h102);
      end
      @(posedge clk); #1 redirect = 1'b1; tgt = 32'h200;
      @(posedge clk); #1 redirect = 1'b0; lat = 3;
      @(negedge clk);
      chk("untrap_misalign", 32'(misalign), 32'h0);
      chk("untrap_pc", pc_o, 32'h200);
      chk("untrap_req", 32'(bus.imem_req_o), 32'h1);

      // Reset while waiting on a response.
      wait_hs(32'h204);
      @(posedge clk); #1 rst_n = 1'b0;
      chk("sb_addr_drained", 32'(exp_addr_q.size()), 32'h0);
      chk("sb_ifid_drained", 32'(exp_ifid_q.size()), 32'h0);
      #1;
      chk("mid_rst_pc", pc_o, 32'h0);
      chk("mid_rst_req", 32'(bus.imem_req_o), 32'h0);
      chk("mid_rst_valid", 32'(bus.ifid_valid_o), 32'h0);
      chk("mid_rst_instr", bus.ifid_instr_o, 32'h0);
      chk("mid_rst_ifid_pc", bus.ifid_pc_o, 32'h0);
      chk("mid_rst_misalign", 32'(misalign), 32'h0);
      lat = 0;
      exp_addr_q.push_back(32'h0);
      exp_addr_q.push_back(32'h4);
      exp_ifid_q.push_back(32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 40 && (exp_addr_q.size() != 0 || exp_ifid_q.size() != 0); i++)
         @(negedge clk);
      @(posedge clk); #1 bus.imem_gnt_i = 1'b0; bus.ifid_ready_i = 1'b0;
      chk("restart_drained", 32'(exp_addr_q.size() + exp_ifid_q.size()), 32'h0);
      repeat (4) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
